// File: rtl/lamp_pkg.sv
// Shared constants and write-FSM state encoding for the LED frame path.
package lamp_pkg;

    // Channel words carried by one LED board.
    localparam int unsigned c_ch_per_board = 32;
    localparam int unsigned c_ledboards    = 30;
    localparam int unsigned c_channels     = c_ledboards * c_ch_per_board;
    localparam int unsigned c_bps          = 12;

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_fill = 2'd1,
        s_full = 2'd2
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module frame_ram #(
    parameter int unsigned c_aw  = 11,
    parameter int unsigned c_bps = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [c_aw-1:0]    i_waddr,
    input  logic [c_bps-1:0]   i_wdata,
    input  logic               i_re,
    input  logic [c_aw-1:0]    i_raddr,
    output logic [c_bps-1:0]   o_rdata
);

    // Sized to the full {bank, channel} address space so that a
    // non-power-of-two channel count never indexes past the array.
    logic [c_bps-1:0] mem [2**c_aw];
    logic [c_bps-1:0] rdata_q;

    // Array write port; contents are intentionally never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; output holds while the read enable is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Ping-pong frame store: host fills the back bank, LED driver reads the front
// bank, and the banks swap only on a driver latch request with a full frame.
module frame_buffer #(
    parameter int unsigned c_ledboards = lamp_pkg::c_ledboards,
    parameter int unsigned c_channels  = c_ledboards * lamp_pkg::c_ch_per_board,
    parameter int unsigned c_addr_w    = (c_channels > 1) ? $clog2(c_channels) : 1,
    parameter int unsigned c_bps       = lamp_pkg::c_bps
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [c_bps-1:0]    i_wr_data,
    input  logic                i_wr_valid,
    input  logic                i_wr_sof,
    output logic                o_wr_ready,
    input  logic [c_addr_w-1:0] i_rd_addr,
    input  logic                i_rd_en,
    output logic [c_bps-1:0]    o_rd_data,
    input  logic                i_drq,
    output logic                o_swap,
    output logic                o_err,
    output logic                o_bank
);

    import lamp_pkg::*;

    localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);

    state_t              state_q, state_d;
    logic [c_addr_w-1:0] waddr_q, waddr_d;
    logic                bank_q,  bank_d;
    logic                swap_q,  swap_d;
    logic                err_q,   err_d;
    logic                drq_q;

    logic                drq_rise;
    logic                we;
    logic [c_addr_w-1:0] wch;

    // Next-state, write strobe and swap decision for the host-side FSM.
    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        bank_d   = bank_q;
        swap_d   = 1'b0;
        err_d    = 1'b0;
        we       = 1'b0;
        wch      = waddr_q;
        drq_rise = i_drq & ~drq_q;

        case (state_q)
            s_idle: begin
                if (i_wr_valid) begin
                    if (i_wr_sof) begin
                        we  = 1'b1;
                        wch = '0;
                        if (c_channels == 1) begin
                            state_d = s_full;
                        end else begin
                            waddr_d = c_addr_w'(1);
                            state_d = s_fill;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            s_fill: begin
                if (i_wr_valid) begin
                    we = 1'b1;
                    if (i_wr_sof) begin
                        // Restart: the aborted partial frame is overwritten.
                        err_d   = 1'b1;
                        wch     = '0;
                        waddr_d = c_addr_w'(1);
                    end else if (waddr_q == c_last) begin
                        waddr_d = '0;
                        state_d = s_full;
                    end else begin
                        waddr_d = waddr_q + c_addr_w'(1);
                    end
                end
            end
            s_full: begin
                if (drq_rise) begin
                    bank_d  = ~bank_q;
                    swap_d  = 1'b1;
                    state_d = s_idle;
                end
            end
            default: begin
                state_d = s_idle;
            end
        endcase
    end

    // State, bank select, pulse outputs and drq edge register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= s_idle;
            waddr_q <= '0;
            bank_q  <= 1'b0;
            swap_q  <= 1'b0;
            err_q   <= 1'b0;
            drq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            bank_q  <= bank_d;
            swap_q  <= swap_d;
            err_q   <= err_d;
            drq_q   <= i_drq;
        end
    end

    assign o_wr_ready = (state_q != s_full);
    assign o_swap     = swap_q;
    assign o_err      = err_q;
    assign o_bank     = bank_q;

    frame_ram #(
        .c_aw  (c_addr_w + 1),
        .c_bps (c_bps)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (we),
        .i_waddr ({~bank_q, wch}),
        .i_wdata (i_wr_data),
        .i_re    (i_rd_en),
        .i_raddr ({bank_q, i_rd_addr}),
        .o_rdata (o_rd_data)
    );

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer (1 board = 32 channels, 12-bit words).
module tb_frame_buffer;

    localparam int unsigned NCH = 32;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [11:0] i_wr_data;
    logic        i_wr_valid;
    logic        i_wr_sof;
    logic        o_wr_ready;
    logic [4:0]  i_rd_addr;
    logic        i_rd_en;
    logic [11:0] o_rd_data;
    logic        i_drq;
    logic        o_swap;
    logic        o_err;
    logic        o_bank;

    int n_cmp = 0;
    int n_mis = 0;

    // Bench-side model of expected bank contents
    logic [11:0] exp_mem [0:1][0:NCH-1];
    int          model_bank = 0;
    int          wptr = 0;
    logic [11:0] exp_q [$];
    int          err_seen = 0;
    int          swap_seen = 0;
    logic [11:0] last_rd;

    frame_buffer #(.c_ledboards(1), .c_bps(12)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_wr_data  (i_wr_data),
        .i_wr_valid (i_wr_valid),
        .i_wr_sof   (i_wr_sof),
        .o_wr_ready (o_wr_ready),
        .i_rd_addr  (i_rd_addr),
        .i_rd_en    (i_rd_en),
        .o_rd_data  (o_rd_data),
        .i_drq      (i_drq),
        .o_swap     (o_swap),
        .o_err      (o_err),
        .o_bank     (o_bank)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        err_seen  += int'(o_err);
        swap_seen += int'(o_swap);
    endtask

    // Present one word and wait (bounded) until it is accepted.
    task automatic send_word(input logic [11:0] d, input logic sof);
        int guard;
        i_wr_data  = d;
        i_wr_sof   = sof;
        i_wr_valid = 1'b1;
        guard = 0;
        while (o_wr_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", {31'd0, o_wr_ready}, 32'd1);
        tick();
        if (sof) wptr = 0;
        exp_mem[1 - model_bank][wptr] = d;
        wptr++;
        i_wr_valid = 1'b0;
        i_wr_sof   = 1'b0;
    endtask

    task automatic send_range(input logic [11:0] base, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            send_word(base + 12'(n), n == 0);
        end
    endtask

    task automatic pulse_drq();
        i_drq = 1'b1;
        tick();
        i_drq = 1'b0;
        tick();
    endtask

    // Read the whole front bank through the scoreboard queue, then check hold.
    task automatic read_bank(input string tag);
        for (int a = 0; a < NCH; a++) begin
            i_rd_addr = 5'(a);
            i_rd_en   = 1'b1;
            exp_q.push_back(exp_mem[model_bank][a]);
            tick();
            last_rd = exp_q.pop_front();
            chk(tag, {20'd0, o_rd_data}, {20'd0, last_rd});
        end
        i_rd_en   = 1'b0;
        i_rd_addr = 5'd3;
        tick();
        tick();
        chk({tag, "_hold"}, {20'd0, o_rd_data}, {20'd0, last_rd});
    endtask

    initial begin
        i_rst      = 1'b1;
        i_wr_data  = '0;
        i_wr_valid = 1'b0;
        i_wr_sof   = 1'b0;
        i_rd_addr  = '0;
        i_rd_en    = 1'b0;
        i_drq      = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_bank",  {31'd0, o_bank},     32'd0);
        chk("rst_ready", {31'd0, o_wr_ready}, 32'd1);
        chk("rst_swap",  {31'd0, o_swap},     32'd0);
        chk("rst_err",   {31'd0, o_err},      32'd0);
        chk("rst_rdata", {20'd0, o_rd_data},  32'd0);
        i_rst = 1'b0;
        tick();

        // Frame A fills bank 1, then frame B's first word is held off in s_full
        err_seen = 0;
        send_range(12'h100, 0, NCH - 1);
        chk("a_full_ready", {31'd0, o_wr_ready}, 32'd0);
        i_wr_valid = 1'b1;
        i_wr_sof   = 1'b1;
        i_wr_data  = 12'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("held_ready", {31'd0, o_wr_ready}, 32'd0);
        end
        i_drq = 1'b1;
        tick();
        chk("a_swap", {31'd0, o_swap},     32'd1);
        chk("a_bank", {31'd0, o_bank},     32'd1);
        chk("a_rdy",  {31'd0, o_wr_ready}, 32'd1);
        model_bank = 1;
        i_drq = 1'b0;
        send_range(12'h200, 0, NCH - 1);
        chk("a_err_none", err_seen, 0);
        read_bank("rd_a");
        swap_seen = 0;
        pulse_drq();
        chk("b_swap_cnt", swap_seen, 1);
        model_bank = 0;
        chk("b_bank", {31'd0, o_bank}, 32'd0);
        read_bank("rd_b");

        // Aborted frame: 10 words, then a fresh sof and a full frame
        err_seen = 0;
        send_range(12'h300, 0, 9);
        send_range(12'h400, 0, NCH - 1);
        chk("abort_err_cnt", err_seen, 1);
        chk("abort_full",    {31'd0, o_wr_ready}, 32'd0);
        swap_seen = 0;
        pulse_drq();
        chk("abort_swap_cnt", swap_seen, 1);
        model_bank = 1;
        read_bank("rd_abort");

        // Early drq during fill: no swap
        send_range(12'h500, 0, 4);
        swap_seen = 0;
        err_seen  = 0;
        pulse_drq();
        chk("early_swap_cnt", swap_seen, 0);
        chk("early_bank", {31'd0, o_bank}, 32'd1);
        send_range(12'h500, 5, NCH - 2);
        // drq rises on the same edge that completes the frame, then held high
        i_drq = 1'b1;
        send_word(12'h500 + 12'(NCH - 1), 1'b0);
        repeat (4) tick();
        chk("samecyc_swap_cnt", swap_seen, 0);
        chk("samecyc_full", {31'd0, o_wr_ready}, 32'd0);
        chk("early_err_cnt", err_seen, 0);
        i_drq = 1'b0;
        tick();
        // Level-high drq for 5 cycles gives one swap
        i_drq = 1'b1;
        repeat (5) tick();
        i_drq = 1'b0;
        tick();
        chk("held_drq_swap_cnt", swap_seen, 1);
        model_bank = 0;
        chk("held_drq_bank", {31'd0, o_bank}, 32'd0);
        read_bank("rd_early");

        // Valid without sof in s_idle: discarded with an error pulse
        i_wr_valid = 1'b1;
        i_wr_sof   = 1'b0;
        i_wr_data  = 12'hABC;
        tick();
        i_wr_valid = 1'b0;
        chk("nosof_err",   {31'd0, o_err},      32'd1);
        chk("nosof_ready", {31'd0, o_wr_ready}, 32'd1);
        tick();
        chk("nosof_err_clr", {31'd0, o_err}, 32'd0);

        // Frame into bank 1, then reset in the middle of the next fill
        send_range(12'h600, 0, NCH - 1);
        pulse_drq();
        model_bank = 1;
        chk("f6_bank", {31'd0, o_bank}, 32'd1);
        read_bank("rd_f6");
        send_range(12'h700, 0, 4);
        i_rst = 1'b1;
        tick();
        tick();
        chk("mid_rst_rdata", {20'd0, o_rd_data}, 32'd0);
        i_rst = 1'b0;
        tick();
        model_bank = 0;
        chk("mid_rst_bank",  {31'd0, o_bank},     32'd0);
        chk("mid_rst_ready", {31'd0, o_wr_ready}, 32'd1);
        chk("mid_rst_swap",  {31'd0, o_swap},     32'd0);
        chk("mid_rst_err",   {31'd0, o_err},      32'd0);
        send_range(12'h800, 0, NCH - 1);
        pulse_drq();
        model_bank = 1;
        chk("post_rst_bank", {31'd0, o_bank}, 32'd1);
        read_bank("rd_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
